// File: rtl/piso_serializer_param.sv
// Parallel-in / serial-out shift register with a ready/valid load port,
// a bit-rate enable, synchronous abort and a done pulse per frame.
// A new word can be accepted on the cycle that consumes the final bit,
// so back-to-back frames run without a gap.
module piso_serializer_param #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b0,
  localparam int CW        = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Abort_In,
  input  logic                  Load_Valid_In,
  output logic                  Load_Ready_Out,
  input  logic [DATA_WIDTH-1:0] Parallel_Data_In,
  input  logic                  Shift_Enable_In,
  output logic                  Serial_Data_Out,
  output logic                  Serial_Valid_Out,
  output logic                  Busy_Out,
  output logic                  Done_Out,
  output logic [CW-1:0]         Bit_Count_Out
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [CW-1:0] FULL_COUNT = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] ONE        = CW'(1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  done_q, done_d;

  // State, shift register, counter and done pulse registers
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next-state: abort beats load, load beats shift
  always_comb begin
    logic last_bit;
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    last_bit = (state_q == SHIFT) && (cnt_q == ONE) && Shift_Enable_In;
    done_d   = last_bit && !Abort_In;
    if (Abort_In) begin
      state_d = IDLE;
      shreg_d = '0;
      cnt_d   = '0;
    end else if (Load_Valid_In && Load_Ready_Out) begin
      state_d = SHIFT;
      shreg_d = Parallel_Data_In;
      cnt_d   = FULL_COUNT;
    end else if ((state_q == SHIFT) && Shift_Enable_In) begin
      if (cnt_q > ONE) begin
        if (MSB_FIRST) shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
        else           shreg_d = {1'b0, shreg_q[DATA_WIDTH-1:1]};
        cnt_d = cnt_q - ONE;
      end else begin
        state_d = IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end
    end
  end

  // Outputs; ready is held low while reset is asserted
  always_comb begin
    Busy_Out         = (state_q == SHIFT);
    Serial_Valid_Out = (state_q == SHIFT);
    Done_Out         = done_q;
    Bit_Count_Out    = cnt_q;
    Serial_Data_Out  = 1'b0;
    if (state_q == SHIFT)
      Serial_Data_Out = MSB_FIRST ? shreg_q[DATA_WIDTH-1] : shreg_q[0];
    Load_Ready_Out = ((state_q == IDLE) ||
                      ((state_q == SHIFT) && (cnt_q == ONE) && Shift_Enable_In)) &&
                     !Abort_In && !Reset_In;
  end

endmodule

// File: tb/tb_piso_serializer_param.sv
// Bench for piso_serializer_param at DATA_WIDTH=8: an LSB-first and an
// MSB-first instance share all inputs and are compared every cycle with a
// frame-level model (current word plus index of the bit on the line).
module tb_piso_serializer_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       abort = 1'b0;
  logic       lv = 1'b0;
  logic [7:0] pd = '0;
  logic       se = 1'b0;

  logic       rdy0, sd0, sv0, busy0, done0;
  logic       rdy1, sd1, sv1, busy1, done1;
  logic [3:0] cnt0, cnt1;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  // Model: frame in flight, its word, and how many bits already consumed
  bit         m_active = 1'b0;
  int         m_idx    = 0;
  logic [7:0] m_word   = '0;
  bit         m_done   = 1'b0;

  always #5 clk = ~clk;

  piso_serializer_param #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .Clk_In(clk), .Reset_In(rst), .Abort_In(abort),
    .Load_Valid_In(lv), .Load_Ready_Out(rdy0), .Parallel_Data_In(pd),
    .Shift_Enable_In(se), .Serial_Data_Out(sd0), .Serial_Valid_Out(sv0),
    .Busy_Out(busy0), .Done_Out(done0), .Bit_Count_Out(cnt0)
  );

  piso_serializer_param #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .Clk_In(clk), .Reset_In(rst), .Abort_In(abort),
    .Load_Valid_In(lv), .Load_Ready_Out(rdy1), .Parallel_Data_In(pd),
    .Shift_Enable_In(se), .Serial_Data_Out(sd1), .Serial_Valid_Out(sv1),
    .Busy_Out(busy1), .Done_Out(done1), .Bit_Count_Out(cnt1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [3:0] exp_cnt;
    logic       exp_s0, exp_s1;
    exp_cnt = m_active ? 4'(8 - m_idx) : 4'd0;
    exp_s0  = m_active ? m_word[m_idx]     : 1'b0;
    exp_s1  = m_active ? m_word[7 - m_idx] : 1'b0;
    check("ser_lsb",   32'(sd0),   32'(exp_s0));
    check("ser_msb",   32'(sd1),   32'(exp_s1));
    check("valid_lsb", 32'(sv0),   32'(m_active));
    check("valid_msb", 32'(sv1),   32'(m_active));
    check("busy_lsb",  32'(busy0), 32'(m_active));
    check("busy_msb",  32'(busy1), 32'(m_active));
    check("cnt_lsb",   32'(cnt0),  32'(exp_cnt));
    check("cnt_msb",   32'(cnt1),  32'(exp_cnt));
    check("done_lsb",  32'(done0), 32'(m_done));
    check("done_msb",  32'(done1), 32'(m_done));
  endtask

  // One clock cycle: check registered outputs, drive inputs, check ready,
  // then advance the model across the coming rising edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic s, input logic a);
    logic last, exp_rdy;
    @(negedge clk);
    check_outputs();
    lv = v; pd = d; se = s; abort = a;
    #1;
    last    = m_active && (m_idx == 7) && s;
    exp_rdy = (!m_active || last) && !a;
    check("ready_lsb", 32'(rdy0), 32'(exp_rdy));
    check("ready_msb", 32'(rdy1), 32'(exp_rdy));
    m_done = last && !a;
    if (a) begin
      m_active = 1'b0;
      m_idx    = 0;
    end else if (v && exp_rdy) begin
      m_word   = d;
      m_idx    = 0;
      m_active = 1'b1;
    end else if (m_active && s) begin
      m_idx++;
      if (m_idx == 8) begin
        m_active = 1'b0;
        m_idx    = 0;
      end
    end
  endtask

  // Assert reset between edges; outputs must clear before any clock edge
  task automatic async_reset();
    #1;
    lv = 1'b0; abort = 1'b0; se = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_ser_lsb",   32'(sd0),   32'd0);
    check("rst_ser_msb",   32'(sd1),   32'd0);
    check("rst_valid_lsb", 32'(sv0),   32'd0);
    check("rst_busy_msb",  32'(busy1), 32'd0);
    check("rst_cnt_lsb",   32'(cnt0),  32'd0);
    check("rst_cnt_msb",   32'(cnt1),  32'd0);
    check("rst_done_lsb",  32'(done0), 32'd0);
    check("rst_ready_lsb", 32'(rdy0),  32'd0);
    check("rst_ready_msb", 32'(rdy1),  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_active = 1'b0;
    m_idx    = 0;
    m_done   = 1'b0;
  endtask

  initial begin
    #2;
    check("init_cnt_lsb",   32'(cnt0), 32'd0);
    check("init_valid_msb", 32'(sv1),  32'd0);
    check("init_ready_lsb", 32'(rdy0), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single frame, constant enable
    cycle(1'b1, 8'h1E, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Enable toggling: every bit held for two cycles
    cycle(1'b1, 8'h1E, 1'b1, 1'b0);
    for (int i = 0; i < 18; i++) cycle(1'b0, 8'h00, (i % 2) == 1, 1'b0);

    // Back-to-back words with valid held high
    cycle(1'b1, 8'h1E, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'hF0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Abort after three bits, with a competing load request
    cycle(1'b1, 8'h1E, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 8'h55, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Reset in the middle of a frame
    cycle(1'b1, 8'hA5, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    async_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic with occasional aborts and resets
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);
      if ((i % 200) == 150) async_reset();
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/piso_serializer_param.md
PISO_SERIALIZER_PARAM -- requirements
Module: piso_serializer_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, frame width in bits; legal range >= 2.
REQ-002 SHALL have parameter MSB_FIRST, default 0: 0 = bit 0 transmitted first, 1 = bit DATA_WIDTH-1 transmitted first.
REQ-003 SHALL derive localparam CW = $clog2(DATA_WIDTH+1), the width of the bit counter.
REQ-004 SHALL have port Clk_In  input  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port Reset_In  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port Abort_In  input  1  synchronous frame abort.
REQ-007 SHALL have port Load_Valid_In  input  1  Parallel_Data_In is valid.
REQ-008 SHALL have port Load_Ready_Out  output  1  block accepts a word this cycle.
REQ-009 SHALL have port Parallel_Data_In  input  DATA_WIDTH  word to serialise.
REQ-010 SHALL have port Shift_Enable_In  input  1  bit-rate tick; the current bit is consumed only when this is high.
REQ-011 SHALL have port Serial_Data_Out  output  1  current serial bit.
REQ-012 SHALL have port Serial_Valid_Out  output  1  Serial_Data_Out carries frame data.
REQ-013 SHALL have port Busy_Out  output  1  frame in progress.
REQ-014 SHALL have port Done_Out  output  1  one-cycle pulse after a frame completes.
REQ-015 SHALL have port Bit_Count_Out  output  CW  bits remaining, including the current bit.

Function
REQ-016 SHALL implement two states: IDLE and SHIFT.
REQ-017 SHALL encode Busy_Out = Serial_Valid_Out = (state == SHIFT), both registered.
REQ-018 SHALL drive Serial_Data_Out from the register's bit 0 when MSB_FIRST=0, and from bit DATA_WIDTH-1 when MSB_FIRST=1.
REQ-019 SHALL force Serial_Data_Out to 0 in IDLE.
REQ-020 SHALL drive Load_Ready_Out combinationally, as (IDLE OR (SHIFT AND Bit_Count_Out==1 AND Shift_Enable_In)) AND NOT Abort_In.
REQ-021 SHALL treat a load as accepted on a rising edge where Load_Valid_In AND Load_Ready_Out are both high.
REQ-022 On an accepted load, SHALL capture Parallel_Data_In, set Bit_Count_Out=DATA_WIDTH and enter SHIFT; the first bit is visible the following cycle.
REQ-023 In SHIFT with Shift_Enable_In=1 and Bit_Count_Out>1, SHALL shift the register one position toward the output end, zero-fill the vacated end, and decrement Bit_Count_Out.
REQ-024 In SHIFT with Shift_Enable_In=0, SHALL hold the register, the counter and all outputs.
REQ-025 On the last bit (Bit_Count_Out==1, Shift_Enable_In=1) with no accepted load, SHALL go to IDLE, clear the register and set the counter to 0.
REQ-026 On the last bit with an accepted load, SHALL reload the register, set the counter to DATA_WIDTH and stay in SHIFT, leaving no gap cycle.
REQ-027 Done_Out SHALL be high for exactly one cycle, the cycle after the last bit is consumed, including on back-to-back reloads.
REQ-028 Abort_In=1 SHALL override load and shift: clear the register, set the counter to 0, enter IDLE and suppress Done_Out.
REQ-029 Load_Valid_In while Load_Ready_Out=0 SHALL be ignored; the source must hold the word.
REQ-030 Bit_Count_Out SHALL never exceed DATA_WIDTH and SHALL never wrap below 0.

Reset
REQ-031 Reset_In=1 SHALL immediately force IDLE, register=0, Bit_Count_Out=0, Serial_Data_Out=0, Serial_Valid_Out=0, Busy_Out=0 and Done_Out=0, at any point including mid-frame.
REQ-032 While Reset_In=1, Load_Ready_Out SHALL be 0.
REQ-033 After Reset_In is released, Load_Ready_Out SHALL be 1 on the next cycle if Abort_In=0.
REQ-034 A frame interrupted by reset SHALL not be resumed and SHALL not produce Done_Out.

Verification (DATA_WIDTH=8)
REQ-035 Reset asserted mid-frame, between clock edges -> all outputs reach the REQ-031 values without waiting for a clock edge.
REQ-036 MSB_FIRST=0, load 8'h1E, Shift_Enable_In=1 constant -> serial sequence 0,1,1,1,1,0,0,0 with Serial_Valid_Out=1 for 8 cycles, Bit_Count_Out counting 8..1, then Done_Out=1 for 1 cycle.
REQ-037 MSB_FIRST=1, load 8'h1E, Shift_Enable_In=1 constant -> serial sequence 0,0,0,1,1,1,1,0, then Done_Out pulse.
REQ-038 Load 8'h1E with Shift_Enable_In toggling 1,0,1,0... -> same bit sequence as REQ-036 spread over 16 cycles, each bit held for 2 cycles.
REQ-039 8'h1E then 8'hF0 presented with Load_Valid_In held high -> 16 contiguous valid bits 0,1,1,1,1,0,0,0,0,0,0,0,1,1,1,1 with no gap, Done_Out pulsing twice.
REQ-040 Abort_In pulsed after 3 bits, with Load_Valid_In=1 in the same cycle -> no load accepted, IDLE next cycle, Bit_Count_Out=0, no Done_Out, Load_Ready_Out=1 the following cycle.
